// File: rtl/l2_interco_pkg.sv
// Shared L2 interconnect definitions: response-pipeline entry, legal
// memory-latency range, and the one-hot ID helper.
package l2_interco_pkg;

  // Initiator ID width carried in a response entry. Banks with a narrower
  // ID port zero-extend into this field.
  localparam int unsigned L2_ID_WIDTH = 9;

  // Request-to-response latency range a bank may be built with.
  localparam int unsigned MEM_LATENCY_MIN = 1;
  localparam int unsigned MEM_LATENCY_MAX = 3;

  // One slot of the response pipeline. wen follows the crossbar encoding:
  // 1 = load, 0 = store. An empty slot is all zeros.
  typedef struct packed {
    logic                   valid;
    logic                   wen;
    logic [L2_ID_WIDTH-1:0] id;
  } resp_entry_t;

  // True when exactly one bit of the ID is set.
  function automatic logic is_one_hot(input logic [L2_ID_WIDTH-1:0] id);
    return (id != '0) && ((id & (id - L2_ID_WIDTH'(1))) == '0);
  endfunction

endpackage

// File: rtl/l2_resp_pipe.sv
// Response pipeline for one L2 bank: delays the request entry by DEPTH
// cycles and pairs load responses with the SRAM read data, which arrives
// one cycle after the request and is registered for the remaining stages.
module l2_resp_pipe
  import l2_interco_pkg::*;
#(
  parameter int unsigned DEPTH      = 1,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  resp_entry_t            entry,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic                   resp_valid,
  output logic [L2_ID_WIDTH-1:0] resp_id,
  output logic [DATA_WIDTH-1:0]  resp_rdata
);

  resp_entry_t           stage_q [DEPTH];
  logic [DATA_WIDTH-1:0] load_data;

  // Entry shift register: stage k holds the request issued k+1 cycles ago.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every stage is cleared, not only the valid bits, so responses in
    // flight vanish at reset and ID/rdata read as 0 immediately; state is
    // updated with <= so each stage samples its neighbour's old value.
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= entry;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  if (DEPTH == 1) begin : g_direct_data
    // Read data is valid in the response cycle itself; forward it unregistered.
    assign load_data = mem_rdata;
  end else begin : g_reg_data
    logic [DATA_WIDTH-1:0] data_q [DEPTH-1];

    // Capture SRAM data the cycle after the request and walk it alongside
    // its entry; data_q[j] belongs to stage_q[j+1].
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) data_q[i] <= '0;
      end else begin
        data_q[0] <= mem_rdata;
        for (int unsigned i = 1; i < DEPTH - 1; i++) data_q[i] <= data_q[i-1];
      end
    end

    assign load_data = data_q[DEPTH-2];
  end

  // Store responses and idle cycles present zero ID and zero data.
  assign resp_valid = stage_q[DEPTH-1].valid;
  assign resp_id    = stage_q[DEPTH-1].valid ? stage_q[DEPTH-1].id : '0;
  assign resp_rdata = (stage_q[DEPTH-1].valid && stage_q[DEPTH-1].wen) ? load_data : '0;

endmodule

// File: rtl/l2_bank_responder.sv
// L2 bank responder: drives a single-port SRAM straight from the crossbar
// request, returns one in-order response per request MEM_LATENCY cycles
// later, and keeps load/store counters plus a sticky bad-ID flag.
// ID_WIDTH must not exceed L2_ID_WIDTH.
module l2_bank_responder
  import l2_interco_pkg::*;
#(
  parameter int unsigned ADDR_MEM_WIDTH = 12,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH       = 9,
  parameter int unsigned MEM_LATENCY    = 1,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      data_req_i,
  input  logic [ADDR_MEM_WIDTH-1:0] data_add_i,
  input  logic                      data_wen_i,
  input  logic [DATA_WIDTH-1:0]     data_wdata_i,
  input  logic [BE_WIDTH-1:0]       data_be_i,
  input  logic [ID_WIDTH-1:0]       data_ID_i,
  output logic                      data_r_valid_o,
  output logic [DATA_WIDTH-1:0]     data_r_rdata_o,
  output logic [ID_WIDTH-1:0]       data_r_ID_o,
  output logic                      mem_csn_o,
  output logic                      mem_wen_o,
  output logic [ADDR_MEM_WIDTH-1:0] mem_add_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [BE_WIDTH-1:0]       mem_be_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  input  logic                      cnt_clr_i,
  output logic [CNT_WIDTH-1:0]      rd_cnt_o,
  output logic [CNT_WIDTH-1:0]      wr_cnt_o,
  output logic                      id_err_o
);

  if (MEM_LATENCY < MEM_LATENCY_MIN || MEM_LATENCY > MEM_LATENCY_MAX) begin : g_bad_latency
    $error("l2_bank_responder: MEM_LATENCY outside legal range");
  end

  resp_entry_t            req_entry;
  logic [L2_ID_WIDTH-1:0] req_id;
  logic [L2_ID_WIDTH-1:0] resp_id;
  logic                   id_ok;
  logic [CNT_WIDTH-1:0]   rd_cnt_q;
  logic [CNT_WIDTH-1:0]   wr_cnt_q;
  logic                   id_err_q;

  // Every request is accepted, so the SRAM port is a plain pass-through.
  assign mem_csn_o   = ~data_req_i;
  assign mem_wen_o   = data_wen_i;
  assign mem_add_o   = data_add_i;
  assign mem_wdata_o = data_wdata_i;
  assign mem_be_o    = data_be_i;

  assign req_id = L2_ID_WIDTH'(data_ID_i);
  assign id_ok  = is_one_hot(req_id);

  // Build the pipeline entry; nothing enters when no request is presented.
  always_comb begin
    // NOTE: default first so every path assigns req_entry and no latch forms.
    req_entry = '0;
    if (data_req_i) begin
      req_entry.valid = 1'b1;
      req_entry.wen   = data_wen_i;
      req_entry.id    = req_id;
    end
  end

  l2_resp_pipe #(
    .DEPTH      (MEM_LATENCY),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_resp_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .entry      (req_entry),
    .mem_rdata  (mem_rdata_i),
    .resp_valid (data_r_valid_o),
    .resp_id    (resp_id),
    .resp_rdata (data_r_rdata_o)
  );

  assign data_r_ID_o = ID_WIDTH'(resp_id);

  // Saturating access counters and sticky bad-ID flag; clear beats counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      id_err_q <= 1'b0;
    end else if (cnt_clr_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      id_err_q <= 1'b0;
    end else if (data_req_i) begin
      if (data_wen_i) begin
        if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + CNT_WIDTH'(1);
      end else begin
        if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + CNT_WIDTH'(1);
      end
      if (!id_ok) id_err_q <= 1'b1;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
  assign id_err_o = id_err_q;

endmodule

// File: doc/l2_bank_responder.md
L2_BANK_RESPONDER -- requirements
Module: l2_bank_responder

Interface
REQ-001 SHALL have parameter ADDR_MEM_WIDTH, default 12, bank word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, data width; BE_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-003 SHALL have parameter ID_WIDTH, default 9, one-hot initiator ID width.
REQ-004 SHALL have parameter MEM_LATENCY, default 1, legal 1..3, request-to-response cycles.
REQ-005 SHALL have parameter CNT_WIDTH, default 32, access counter width.
REQ-006 One clock, clk; reset is asynchronous and active-low, rst_n.
REQ-007 SHALL have ports, in order:
 clk  in  1  clock
 rst_n  in  1  async active-low reset
 data_req_i  in  1  request from crossbar
 data_add_i  in  ADDR_MEM_WIDTH  word address
 data_wen_i  in  1  0 = store, 1 = load
 data_wdata_i  in  DATA_WIDTH  write data
 data_be_i  in  BE_WIDTH  byte enables
 data_ID_i  in  ID_WIDTH  one-hot initiator ID
 data_r_valid_o  out  1  response valid (loads and stores)
 data_r_rdata_o  out  DATA_WIDTH  load data
 data_r_ID_o  out  ID_WIDTH  ID echoed with response
 mem_csn_o  out  1  SRAM chip select, active low
 mem_wen_o  out  1  SRAM write enable, active low
 mem_add_o  out  ADDR_MEM_WIDTH  SRAM address
 mem_wdata_o  out  DATA_WIDTH  SRAM write data
 mem_be_o  out  BE_WIDTH  SRAM byte enables
 mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid 1 cycle after a read
 cnt_clr_i  in  1  synchronous clear of counters and error flag
 rd_cnt_o  out  CNT_WIDTH  accepted loads
 wr_cnt_o  out  CNT_WIDTH  accepted stores
 id_err_o  out  1  sticky: request with non-one-hot ID

Function
REQ-008 Every request SHALL be accepted in the cycle it is presented; no grant port, no back-pressure.
REQ-009 mem_csn_o = ~data_req_i; mem_wen_o = data_wen_i; mem_add_o/mem_wdata_o/mem_be_o = inputs; combinational, zero latency.
REQ-010 A request accepted in cycle t SHALL produce exactly one data_r_valid_o pulse in cycle t+MEM_LATENCY carrying its data_ID_i on data_r_ID_o.
REQ-011 Responses SHALL be in request order; back-to-back requests SHALL give back-to-back responses (throughput 1/cycle).
REQ-012 MEM_LATENCY=1: load data_r_rdata_o = mem_rdata_i directly; MEM_LATENCY>1: mem_rdata_i captured at t+1 and registered through MEM_LATENCY-1 stages.
REQ-013 Store responses and idle cycles SHALL drive data_r_rdata_o = 0 and data_r_ID_o = 0 when data_r_valid_o = 0.
REQ-014 rd_cnt_o/wr_cnt_o SHALL increment by 1 the cycle after each accepted load/store, saturating at all-ones.
REQ-015 id_err_o SHALL set the cycle after a request whose data_ID_i is not exactly one-hot, and hold until cnt_clr_i or reset.
REQ-016 cnt_clr_i SHALL zero counters and id_err_o next cycle; a simultaneous request SHALL not be counted (clear wins).
REQ-017 Requests while data_req_i=0 SHALL have no effect regardless of other inputs.

Reset
REQ-018 On rst_n low, all pipeline stages, data_r_valid_o, data_r_rdata_o, data_r_ID_o, counters and id_err_o SHALL be 0 immediately.
REQ-019 Responses in flight at reset assertion SHALL be discarded; no response pulse after reset release without a new request.

Structure
REQ-020 Response-pipeline entry type (valid, wen, ID) and MEM_LATENCY legal range SHALL reside in shared package l2_interco_pkg.
REQ-021 Single sub-module l2_resp_pipe (parameterized-depth valid/ID/data shift stage); counters and error logic in top.

Verification
REQ-022 MEM_LATENCY=1: store addr 0x010 data 0xDEADBEEF_01234567 BE 0xFF ID 0x004, then load 0x010 ID 0x020 -> valid at t+1 with ID 0x004 rdata 0; valid at t+2 with ID 0x020 rdata 0xDEADBEEF_01234567.
REQ-023 MEM_LATENCY=3: 8 back-to-back loads IDs 0x001..0x080 -> 8 consecutive valid pulses starting t+3, IDs in order.
REQ-024 Store BE 0x0F data all-ones over 0 -> subsequent load returns 0x00000000_FFFFFFFF.
REQ-025 Request ID 0x003 -> id_err_o=1 next cycle, stays 1; cnt_clr_i pulse -> 0; ID 0x000 also sets it.
REQ-026 Counters preloaded near all-ones via 2^CNT_WIDTH stores (CNT_WIDTH=4 build) -> wr_cnt_o saturates at 0xF.
REQ-027 Reset asserted with 2 loads in flight (MEM_LATENCY=2) -> no valid pulse after release; all outputs 0.
